// File: rtl/pipelined_register_file.sv
// pipelined_register_file: multi-port register file with registered requests, registered read data,
// byte-masked writes, highest-port-wins conflict resolution and optional write-to-read bypass.
module pipelined_register_file #(
  parameter int WIDTH       = 64,
  parameter int DEPTH       = 128,
  parameter int READ_PORTS  = 8,
  parameter int WRITE_PORTS = 4,
  parameter int BYPASS      = 1,
  parameter int ZERO_REG    = 0,
  localparam int NB = WIDTH / 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [READ_PORTS-1:0]        rd_en,
  input  logic [READ_PORTS*AW-1:0]     rd_addr,
  input  logic [WRITE_PORTS-1:0]       wr_en,
  input  logic [WRITE_PORTS*AW-1:0]    wr_addr,
  input  logic [WRITE_PORTS*WIDTH-1:0] wr_data,
  input  logic [WRITE_PORTS*NB-1:0]    wr_mask,
  output logic [READ_PORTS*WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]        rd_valid
);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] LIM = AW1'(DEPTH);

  logic [READ_PORTS-1:0]        r_rd_en;
  logic [READ_PORTS*AW-1:0]     r_rd_addr;
  logic [WRITE_PORTS-1:0]       r_wr_en;
  logic [WRITE_PORTS*AW-1:0]    r_wr_addr;
  logic [WRITE_PORTS*WIDTH-1:0] r_wr_data;
  logic [WRITE_PORTS*NB-1:0]    r_wr_mask;
  logic [READ_PORTS*WIDTH-1:0]  r_rd_data;
  logic [READ_PORTS-1:0]        r_rd_valid;
  logic [WIDTH-1:0]             r_mem [DEPTH];
  logic [WRITE_PORTS-1:0]       w_wr_ok;
  logic [READ_PORTS*WIDTH-1:0]  w_rd_val;
  logic [AW-1:0]                w_ra;
  logic [WIDTH-1:0]             w_rv;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < LIM;
  endfunction

  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < WRITE_PORTS; p++)
      w_wr_ok[p] = r_wr_en[p] && in_range(r_wr_addr[p*AW +: AW]) &&
                   !(ZERO_REG != 0 && r_wr_addr[p*AW +: AW] == '0);
  end

  // Ascending port order lets the highest enabling port win each lane.
  always_comb begin
    w_rd_val = '0;
    w_ra = '0;
    w_rv = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      w_ra = r_rd_addr[r*AW +: AW];
      w_rv = in_range(w_ra) ? r_mem[w_ra] : '0;
      for (int p = 0; p < WRITE_PORTS; p++)
        for (int b = 0; b < NB; b++)
          if (BYPASS != 0 && w_wr_ok[p] && r_wr_mask[p*NB+b] && r_wr_addr[p*AW +: AW] == w_ra)
            w_rv[b*8 +: 8] = r_wr_data[p*WIDTH + b*8 +: 8];
      w_rd_val[r*WIDTH +: WIDTH] = (ZERO_REG != 0 && w_ra == '0) ? '0 : w_rv;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++)
        for (int b = 0; b < NB; b++)
          if (w_wr_ok[p] && r_wr_mask[p*NB+b])
            r_mem[r_wr_addr[p*AW +: AW]][b*8 +: 8] <= r_wr_data[p*WIDTH + b*8 +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_en    <= '0;
      r_rd_addr  <= '0;
      r_wr_en    <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      r_rd_en    <= rd_en;
      r_rd_addr  <= rd_addr;
      r_wr_en    <= wr_en;
      r_wr_addr  <= wr_addr;
      r_wr_data  <= wr_data;
      r_wr_mask  <= wr_mask;
      r_rd_valid <= r_rd_en;
      for (int r = 0; r < READ_PORTS; r++)
        if (r_rd_en[r]) r_rd_data[r*WIDTH +: WIDTH] <= w_rd_val[r*WIDTH +: WIDTH];
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
endmodule

// File: tb/tb_pipelined_register_file.sv
// tb_pipelined_register_file: two builds (bypass+zero-entry+100 deep, plain 128 deep) driven in lockstep
// and checked against an array model of the register file.
module tb_pipelined_register_file;
  localparam int RP = 4;
  localparam int WP = 4;
  localparam int W  = 64;
  localparam int NB = 8;
  localparam int AW = 7;
  localparam int DEP [2] = '{100, 128};
  localparam int BYP [2] = '{1, 0};
  localparam int ZR  [2] = '{1, 0};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [RP-1:0]    rd_en;
  logic [RP*AW-1:0] rd_addr;
  logic [WP-1:0]    wr_en;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*W-1:0]  wr_data;
  logic [WP*NB-1:0] wr_mask;
  logic [RP*W-1:0]  rd_data0, rd_data1;
  logic [RP-1:0]    rd_valid0, rd_valid1;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] m    [2][128];
  logic [W-1:0] hold [2][RP];
  logic [W-1:0] pval [2][RP];
  logic [RP-1:0] pen;

  pipelined_register_file #(.WIDTH(W), .DEPTH(100), .READ_PORTS(RP), .WRITE_PORTS(WP),
                            .BYPASS(1), .ZERO_REG(1)) u0 (
    .clock(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .rd_data(rd_data0), .rd_valid(rd_valid0));

  pipelined_register_file #(.WIDTH(W), .DEPTH(128), .READ_PORTS(RP), .WRITE_PORTS(WP),
                            .BYPASS(0), .ZERO_REG(0)) u1 (
    .clock(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .rd_data(rd_data1), .rd_valid(rd_valid1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [W-1:0] d, input logic [NB-1:0] k);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*W +: W] = d;
    wr_mask[p*NB +: NB] = k;
  endtask

  // Per lane, the highest-index port writing address a with that lane enabled supplies the byte.
  function automatic logic [W-1:0] merged(input int a, input logic [W-1:0] base);
    logic [W-1:0] v = base;
    for (int b = 0; b < NB; b++)
      for (int p = WP - 1; p >= 0; p--)
        if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a && wr_mask[p*NB + b]) begin
          v[b*8 +: 8] = wr_data[p*W + b*8 +: 8];
          break;
        end
    return v;
  endfunction

  function automatic logic [W-1:0] rdexp(input int d, input int a);
    if (a >= DEP[d] || (ZR[d] != 0 && a == 0)) return '0;
    return BYP[d] != 0 ? merged(a, m[d][a]) : m[d][a];
  endfunction

  task automatic step();
    logic [W-1:0] cv [2][RP];
    logic [RP-1:0] ce;
    ce = rd_en;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < RP; r++) cv[d][r] = rdexp(d, int'(rd_addr[r*AW +: AW]));
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < WP; p++) begin
        int a = int'(wr_addr[p*AW +: AW]);
        if (wr_en[p] && a < DEP[d] && !(ZR[d] != 0 && a == 0)) m[d][a] = merged(a, m[d][a]);
      end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < RP; r++) begin
        if (pen[r]) hold[d][r] = pval[d][r];
        chk($sformatf("u%0d.valid[%0d]", d, r), W'(d != 0 ? rd_valid1[r] : rd_valid0[r]), W'(pen[r]));
        chk($sformatf("u%0d.data[%0d]", d, r), d != 0 ? rd_data1[r*W +: W] : rd_data0[r*W +: W], hold[d][r]);
      end
    pen = ce;
    pval = cv;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst.valid0", W'(rd_valid0), '0);
    chk("rst.valid1", W'(rd_valid1), '0);
    chk("rst.data0", rd_data0[W-1:0] | rd_data0[W +: W] | rd_data0[2*W +: W] | rd_data0[3*W +: W], '0);
    chk("rst.data1", rd_data1[W-1:0] | rd_data1[W +: W] | rd_data1[2*W +: W] | rd_data1[3*W +: W], '0);
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 128; a++) m[d][a] = '0;
      for (int r = 0; r < RP; r++) hold[d][r] = '0;
    end
    pen = '0;
    clr();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    #2;
    do_reset();
    // contents clear after reset
    set_rd(0, 5); set_rd(1, 99); set_rd(2, 127); set_rd(3, 5);
    step(); clr(); step();
    chk("rst_clear.valid", W'(rd_valid0), 64'hf);
    chk("rst_clear.data", rd_data1[W +: W], '0);
    // byte-masked write
    set_wr(0, 3, '1, 8'hFF); step();
    clr(); set_wr(0, 3, 64'h1122_3344_5566_7788, 8'h0F); step();
    clr(); set_rd(0, 3); step(); clr(); step();
    chk("bytemask.u0", rd_data0[W-1:0], 64'hFFFF_FFFF_5566_7788);
    chk("bytemask.u1", rd_data1[W-1:0], 64'hFFFF_FFFF_5566_7788);
    // same-cycle conflict on address 10
    set_wr(0, 10, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    set_wr(3, 10, 64'hBBBB_BBBB_BBBB_BBBB, 8'h0F); step();
    clr(); set_rd(0, 10); step(); clr(); step();
    chk("conflict.u0", rd_data0[W-1:0], 64'hAAAA_AAAA_BBBB_BBBB);
    chk("conflict.u1", rd_data1[W-1:0], 64'hAAAA_AAAA_BBBB_BBBB);
    // bypass versus old data
    set_wr(0, 7, 64'h1, 8'hFF); step();
    clr(); set_wr(0, 7, 64'h2, 8'hFF); set_rd(0, 7); step();
    clr(); set_rd(0, 7); step();
    chk("bypass.same.u0", rd_data0[W-1:0], 64'h2);
    chk("bypass.same.u1", rd_data1[W-1:0], 64'h1);
    clr(); step();
    chk("bypass.later.u0", rd_data0[W-1:0], 64'h2);
    chk("bypass.later.u1", rd_data1[W-1:0], 64'h2);
    // zero entry
    set_wr(1, 0, 64'h55, 8'hFF); step();
    clr(); set_rd(2, 0); step(); clr(); step();
    chk("zero.u0", rd_data0[2*W +: W], '0);
    chk("zero.u1", rd_data1[2*W +: W], 64'h55);
    // out-of-range write must not alias
    set_wr(2, 120, 64'h77, 8'hFF); step();
    clr(); set_rd(0, 120); set_rd(1, 20); set_rd(2, 56); set_rd(3, 99); step(); clr(); step();
    chk("range.u0.data", rd_data0[W-1:0], '0);
    chk("range.u0.valid", W'(rd_valid0[0]), 64'h1);
    chk("range.u1.data", rd_data1[W-1:0], 64'h77);
    // valid tracking 1,0,1
    set_rd(0, 3); step();
    clr(); step();
    chk("toggle.1", W'(rd_valid0[0]), 64'h1);
    set_rd(0, 3); step();
    chk("toggle.0", W'(rd_valid0[0]), 64'h0);
    clr(); step();
    chk("toggle.1b", W'(rd_valid1[0]), 64'h1);
    // random traffic biased toward a few hot addresses for conflicts and bypass hits
    for (int i = 0; i < 300; i++) begin
      clr();
      for (int r = 0; r < RP; r++)
        if ($urandom_range(0, 3) != 0)
          set_rd(r, $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 127)));
      for (int p = 0; p < WP; p++)
        if ($urandom_range(0, 1) != 0)
          set_wr(p, $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 127)),
                 {$urandom, $urandom}, NB'($urandom_range(0, 255)));
      step();
    end
    // reset with a read sitting in stage 1
    clr(); set_rd(0, 3); set_rd(1, 10); set_rd(2, 7); set_rd(3, 5); step();
    do_reset();
    step();
    chk("midrst.novalid0", W'(rd_valid0), '0);
    chk("midrst.novalid1", W'(rd_valid1), '0);
    for (int a = 0; a < 128; a += RP) begin
      clr();
      for (int r = 0; r < RP; r++) set_rd(r, a + r);
      step();
    end
    clr(); step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
